c906_mem_march_bist: RTL and testbench

- Synthesizable March C- built-in self-test engine for one single-port SRAM instance (BHT, ICACHE, DCACHE or MMU arrays).
- Drives the SRAM's active-low CEN/WEN interface, checks read data and produces the pass flag that the memory/ICG test bench samples.
- Producer side of the per-array "mem_test_pass" status; one instance is placed per array under test.

---
 rtl/c906_mem_march_bist.sv | 141 ++++++++++++++
 tb/tb_c906_mem_march_bist.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c906_mem_march_bist.sv
//------------------------------------------------------------------------------
// c906_mem_march_bist : March C- self-test engine for one single-port SRAM.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module c906_mem_march_bist #(
   parameter int                    ADDR_WIDTH = 7,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] DATA_BG    = {DATA_WIDTH{1'b0}}
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  bist_start,
   output logic                  mem_cen,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  bist_busy,
   output logic                  bist_done,
   output logic                  bist_pass,
   output logic [ADDR_WIDTH-1:0] bist_fail_addr
);

   localparam logic [DATA_WIDTH-1:0] P0        = DATA_BG;
   localparam logic [DATA_WIDTH-1:0] P1        = ~DATA_BG;
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_M0   = 4'd1,
      S_M1   = 4'd2,
      S_M2   = 4'd3,
      S_M3   = 4'd4,
      S_M4   = 4'd5,
      S_M5   = 4'd6,
      S_DONE = 4'd7
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  phase;

   logic                  in_march;
   logic                  rw_elem;
   logic                  up_elem;
   logic                  elem_end;
   logic [DATA_WIDTH-1:0] exp_data;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  miscompare;

   always_comb begin
      in_march = (state == S_M0) || (state == S_M1) || (state == S_M2) ||
                 (state == S_M3) || (state == S_M4) || (state == S_M5);
      rw_elem  = (state == S_M1) || (state == S_M2) || (state == S_M3) || (state == S_M4);
      up_elem  = (state == S_M0) || (state == S_M1) || (state == S_M2);
      elem_end = up_elem ? (addr == ADDR_LAST) : (addr == '0);
      exp_data = ((state == S_M2) || (state == S_M4)) ? P1 : P0;
      wr_data  = ((state == S_M1) || (state == S_M3)) ? P1 : P0;
      // Case-inequality so an X read back is treated as a miscompare.
      miscompare = in_march && (state != S_M0) && phase && (mem_dout !== exp_data);
   end

   always_comb begin
      mem_cen   = !in_march || ((state == S_M5) && phase);
      mem_wen   = !((state == S_M0) || (rw_elem && phase));
      mem_addr  = in_march ? addr : '0;
      mem_din   = (in_march && (state != S_M5)) ? wr_data : '0;
      bist_busy = in_march;
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state          <= S_IDLE;
         addr           <= '0;
         phase          <= 1'b0;
         bist_done      <= 1'b0;
         bist_pass      <= 1'b0;
         bist_fail_addr <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bist_start) begin
                  state          <= S_M0;
                  addr           <= '0;
                  phase          <= 1'b0;
                  bist_done      <= 1'b0;
                  bist_pass      <= 1'b0;
                  bist_fail_addr <= '0;
               end
            end
            S_M0: begin
               if (elem_end) begin
                  state <= S_M1;
                  addr  <= '0;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            S_M1, S_M2, S_M3, S_M4, S_M5: begin
               if (!phase) begin
                  phase <= 1'b1;
               end else begin
                  phase <= 1'b0;
                  if (miscompare) begin
                     state          <= S_DONE;
                     bist_done      <= 1'b1;
                     bist_pass      <= 1'b0;
                     bist_fail_addr <= addr;
                  end else if (elem_end) begin
                     // Next element restarts from its own start address.
                     case (state)
                        S_M1:    begin state <= S_M2; addr <= '0;        end
                        S_M2:    begin state <= S_M3; addr <= ADDR_LAST; end
                        S_M3:    begin state <= S_M4; addr <= ADDR_LAST; end
                        S_M4:    begin state <= S_M5; addr <= ADDR_LAST; end
                        default: begin
                           state     <= S_DONE;
                           addr      <= '0;
                           bist_done <= 1'b1;
                           bist_pass <= 1'b1;
                        end
                     endcase
                  end else begin
                     addr <= up_elem ? (addr + 1'b1) : (addr - 1'b1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               addr  <= '0;
               phase <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_c906_mem_march_bist.sv
//------------------------------------------------------------------------------
// tb_c906_mem_march_bist : scoreboard bench for the March C- BIST engine.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_c906_mem_march_bist;

   localparam int          AW   = 3;
   localparam int          DW   = 32;
   localparam int          N    = 8;
   localparam logic [31:0] BG_B = 32'hA5A5_A5A5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, start_a, start_b;
   logic          cen_a, wen_a, busy_a, done_a, pass_a;
   logic [AW-1:0] addr_a, fail_a;
   logic [DW-1:0] din_a, dout_a;
   logic          cen_b, wen_b, busy_b, done_b, pass_b;
   logic [AW-1:0] addr_b, fail_b;
   logic [DW-1:0] din_b, dout_b;

   int   fault_mode;
   logic bg_fault;
   logic acc_en;
   int   tests = 0;
   int   fails = 0;
   int   stray = 0;

   c906_mem_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BG(32'h0)) u_dut_a (
      .forever_cpuclk(clk), .cpurst_b(rst_n), .bist_start(start_a),
      .mem_cen(cen_a), .mem_wen(wen_a), .mem_addr(addr_a), .mem_din(din_a),
      .mem_dout(dout_a), .bist_busy(busy_a), .bist_done(done_a),
      .bist_pass(pass_a), .bist_fail_addr(fail_a));

   c906_mem_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BG(BG_B)) u_dut_b (
      .forever_cpuclk(clk), .cpurst_b(rst_n), .bist_start(start_b),
      .mem_cen(cen_b), .mem_wen(wen_b), .mem_addr(addr_b), .mem_din(din_b),
      .mem_dout(dout_b), .bist_busy(busy_b), .bist_done(done_b),
      .bist_pass(pass_b), .bist_fail_addr(fail_b));

   // SRAM models: fault 1 = addr 5 bit 0 stuck-at-1, fault 2 = writes to 3 also hit 2.
   logic [DW-1:0] mem_a [N];
   logic [DW-1:0] mem_b [N];

   always @(posedge clk) begin
      if (!cen_a) begin
         if (!wen_a) begin
            mem_a[addr_a] <= din_a;
            if (fault_mode == 2 && addr_a == 3'd3) mem_a[2] <= din_a;
         end else begin
            dout_a <= mem_a[addr_a];
            if (fault_mode == 1 && addr_a == 3'd5) dout_a <= mem_a[addr_a] | 32'h1;
         end
      end
   end

   always @(posedge clk) begin
      if (!cen_b) begin
         if (!wen_b) mem_b[addr_b] <= din_b;
         else begin
            dout_b <= mem_b[addr_b];
            if (bg_fault && addr_b == 3'd0) dout_b <= mem_b[addr_b] & 32'h7FFF_FFFF;
         end
      end
   end

   typedef struct {
      logic          cen;
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
   } acc_t;

   typedef struct {
      int            cycles;
      logic          pass;
      logic [AW-1:0] fail_addr;
   } res_t;

   acc_t acc_q[$];
   res_t res_a_q[$];
   res_t res_b_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_acc(input logic cen, input logic wen, input int a, input logic [DW-1:0] d);
      acc_t e;
      e.cen = cen; e.wen = wen; e.addr = AW'(a); e.din = d;
      acc_q.push_back(e);
   endtask

   // Expected SRAM access per busy cycle for a fault-free March C- run.
   task automatic push_march(input logic [DW-1:0] p0);
      for (int a = 0; a < N; a++) push_acc(1'b0, 1'b0, a, p0);
      for (int a = 0; a < N; a++) begin push_acc(1'b0, 1'b1, a, '0); push_acc(1'b0, 1'b0, a, ~p0); end
      for (int a = 0; a < N; a++) begin push_acc(1'b0, 1'b1, a, '0); push_acc(1'b0, 1'b0, a, p0);  end
      for (int a = N-1; a >= 0; a--) begin push_acc(1'b0, 1'b1, a, '0); push_acc(1'b0, 1'b0, a, ~p0); end
      for (int a = N-1; a >= 0; a--) begin push_acc(1'b0, 1'b1, a, '0); push_acc(1'b0, 1'b0, a, p0);  end
      for (int a = N-1; a >= 0; a--) begin push_acc(1'b0, 1'b1, a, '0); push_acc(1'b1, 1'b1, 0, '0);  end
   endtask

   // Access monitor for DUT A.
   always @(negedge clk) begin
      acc_t e;
      if (!rst_n) begin
         acc_q.delete();
      end else begin
         if (!busy_a && !cen_a) stray++;
         if (busy_a && acc_en) begin
            if (acc_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL acc_extra: busy access at addr %0d with no expected entry", addr_a);
            end else begin
               e = acc_q.pop_front();
               if (e.cen) check("acc_idle_slot", 64'(cen_a), 64'd1);
               else check("acc_seq",
                          64'({cen_a, wen_a, addr_a, (e.wen ? 32'h0 : din_a)}),
                          64'({e.cen, e.wen, e.addr, (e.wen ? 32'h0 : e.din)}));
            end
         end
      end
   end

   // Result monitors: pop when bist_done rises.
   int   busy_cnt_a, busy_cnt_b;
   logic done_q_a, done_q_b;

   always @(negedge clk) begin
      res_t r;
      if (!rst_n) begin
         busy_cnt_a = 0; done_q_a = 1'b0;
      end else begin
         if (busy_a) busy_cnt_a++;
         if (done_a && !done_q_a) begin
            if (res_a_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL res_a_unexpected: done with pass=%0b fail_addr=%0d", pass_a, fail_a);
            end else begin
               r = res_a_q.pop_front();
               check("a_busy_cycles", 64'(busy_cnt_a), 64'(r.cycles));
               check("a_pass", 64'(pass_a), 64'(r.pass));
               check("a_fail_addr", 64'(fail_a), 64'(r.fail_addr));
            end
            busy_cnt_a = 0;
         end
         done_q_a = done_a;
      end
   end

   always @(negedge clk) begin
      res_t r;
      if (!rst_n) begin
         busy_cnt_b = 0; done_q_b = 1'b0;
      end else begin
         if (busy_b) busy_cnt_b++;
         if (done_b && !done_q_b) begin
            if (res_b_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL res_b_unexpected: done with pass=%0b fail_addr=%0d", pass_b, fail_b);
            end else begin
               r = res_b_q.pop_front();
               check("b_busy_cycles", 64'(busy_cnt_b), 64'(r.cycles));
               check("b_pass", 64'(pass_b), 64'(r.pass));
               check("b_fail_addr", 64'(fail_b), 64'(r.fail_addr));
            end
            busy_cnt_b = 0;
         end
         done_q_b = done_b;
      end
   end

   task automatic push_res_a(input int c, input logic p, input int fa);
      res_t r; r.cycles = c; r.pass = p; r.fail_addr = AW'(fa); res_a_q.push_back(r);
   endtask

   task automatic push_res_b(input int c, input logic p, input int fa);
      res_t r; r.cycles = c; r.pass = p; r.fail_addr = AW'(fa); res_b_q.push_back(r);
   endtask

   // Returns one cycle into M0 (busy cycle 0).
   task automatic pulse_a();
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
   endtask

   task automatic pulse_b();
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
   endtask

   task automatic wait_done_a(input int limit);
      int i = 0;
      while (!done_a && i < limit) begin @(negedge clk); i++; end
      if (!done_a) begin
         tests++; fails++;
         $display("FAIL a_timeout: done=%0b after %0d cycles, required 1", done_a, limit);
      end
      @(negedge clk);
   endtask

   task automatic wait_done_b(input int limit);
      int i = 0;
      while (!done_b && i < limit) begin @(negedge clk); i++; end
      if (!done_b) begin
         tests++; fails++;
         $display("FAIL b_timeout: done=%0b after %0d cycles, required 1", done_b, limit);
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      fault_mode = 0; bg_fault = 1'b0; acc_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cen_wen", 64'({cen_a, wen_a}), 64'(2'b11));
      check("rst_addr", 64'(addr_a), 64'd0);
      check("rst_din", 64'(din_a), 64'd0);
      check("rst_busy_done_pass", 64'({busy_a, done_a, pass_a}), 64'(3'b000));
      check("rst_fail_addr", 64'(fail_a), 64'd0);
      rst_n = 1'b1;

      // Fault-free run with full access-order check.
      push_march(32'h0); acc_en = 1'b1; push_res_a(88, 1'b1, 0);
      pulse_a(); wait_done_a(200);
      check("idle_cen_after_done", 64'({cen_a, wen_a, busy_a}), 64'(3'b110));

      // Start pulsed during busy cycle 30 must be ignored.
      push_march(32'h0); push_res_a(88, 1'b1, 0);
      pulse_a();
      repeat (30) @(posedge clk);
      #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      wait_done_a(200);

      // Restart from DONE clears done/pass first.
      push_march(32'h0); push_res_a(88, 1'b1, 0);
      pulse_a();
      check("restart_clears", 64'({done_a, pass_a}), 64'(2'b00));
      wait_done_a(200);

      // Stuck-at-1 at addr 5: compare in busy cycle 19, done from cycle 20.
      acc_en = 1'b0; fault_mode = 1; push_res_a(20, 1'b0, 5);
      pulse_a(); wait_done_a(200);
      repeat (5) @(negedge clk);
      check("no_access_after_fail", 64'({cen_a, busy_a, done_a}), 64'(3'b101));

      // Decoder fault 3->2: caught at M3 r0 of addr 2 (busy cycle 51).
      fault_mode = 2; push_res_a(52, 1'b0, 2);
      pulse_a(); wait_done_a(200);

      // Async reset in the middle of M2.
      fault_mode = 0; acc_en = 1'b1; push_march(32'h0);
      pulse_a();
      repeat (30) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_cen_wen_busy", 64'({cen_a, wen_a, busy_a}), 64'(3'b110));
      check("midrst_addr_din", 64'({addr_a, din_a}), 64'd0);
      check("midrst_done_pass_fail", 64'({done_a, pass_a, fail_a}), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push_march(32'h0); push_res_a(88, 1'b1, 0);
      pulse_a(); wait_done_a(200);

      // Non-zero background: clean run, then bit 31 of addr 0 stuck-at-0.
      push_res_b(88, 1'b1, 0);
      pulse_b(); wait_done_b(200);
      // P0 has bit 31 set, so the fault is already visible on the M1 r0 of addr 0.
      bg_fault = 1'b1; push_res_b(10, 1'b0, 0);
      pulse_b(); wait_done_b(200);

      check("acc_q_drained", 64'(acc_q.size()), 64'd0);
      check("res_q_drained", 64'(res_a_q.size() + res_b_q.size()), 64'd0);
      check("stray_access", 64'(stray), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
